clock_freq_monitor: RTL

// - Consumer-side check for a PLL-generated clock: confirms the generated clock runs at the right frequency.
// - The monitored domain divides its clock and drives a toggle line, mon_toggle, into this block.
// - This block counts toggle transitions over a fixed window of the reference clock (14.318 MHz board clock).
// - Window count outside range: raises fault and holds sys_reset_n low.
// - In range for GOOD_WINDOWS consecutive windows: raises clk_ok and releases sys_reset_n.

---
 rtl/freq_mon_pkg.sv | 23 ++
 rtl/freq_mon_sync.sv | 28 ++
 rtl/clock_freq_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/freq_mon_pkg.sv
// Shared types and default constants for the reference-clock frequency monitor.
// Defaults target a 1 ms window on the 14.318 MHz board clock.
package freq_mon_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam int DEF_WINDOW_CYCLES = 14318;
    localparam int DEF_EXP_MIN       = 1300;
    localparam int DEF_EXP_MAX       = 1385;
    localparam int DEF_GOOD_WINDOWS  = 4;
    localparam int DEF_CNT_W         = 16;

    // Counter width for values 0..value-1; never narrower than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/freq_mon_sync.sv
// Brings the asynchronous toggle line into clk through two flops, then compares
// against a history flop so every rising or falling transition yields a one-cycle pulse.
module freq_mon_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic toggle_edge
);

    logic sync1;
    logic sync2;
    logic hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            hist  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            hist  <= sync2;
        end
    end

    assign toggle_edge = sync2 ^ hist;

endmodule

// File: rtl/clock_freq_monitor.sv
// Counts monitored-clock toggle transitions per reference window and gates the
// monitored domain's reset until enough consecutive windows land in range.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | measurement stopped, counters held at zero, outputs deasserted
// ACQUIRE | measuring, counting consecutive in-range windows towards lock
// LOCKED  | frequency verified, clk_ok and sys_reset_n released
// FAULT   | lost lock; fault held while re-counting in-range windows
module clock_freq_monitor
    import freq_mon_pkg::*;
#(
    parameter int WINDOW_CYCLES = DEF_WINDOW_CYCLES,
    parameter int EXP_MIN       = DEF_EXP_MIN,
    parameter int EXP_MAX       = DEF_EXP_MAX,
    parameter int GOOD_WINDOWS  = DEF_GOOD_WINDOWS,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             mon_toggle,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             clk_ok,
    output logic             fault,
    output logic             sys_reset_n
);

    localparam int WW = clog2_min1(WINDOW_CYCLES);
    localparam int GW = clog2_min1(GOOD_WINDOWS);

    localparam logic [WW-1:0]    WCNT_LAST = WW'(WINDOW_CYCLES - 1);
    localparam logic [GW-1:0]    GOOD_LAST = GW'(GOOD_WINDOWS - 1);
    localparam logic [CNT_W-1:0] EXP_MIN_C = CNT_W'(EXP_MIN);
    localparam logic [CNT_W-1:0] EXP_MAX_C = CNT_W'(EXP_MAX);

    state_t           state;
    state_t           state_nxt;
    logic [WW-1:0]    wcnt;
    logic [CNT_W-1:0] ecnt;
    logic [GW-1:0]    gcnt;
    logic [GW-1:0]    gcnt_nxt;
    logic             fault_nxt;
    logic             toggle_edge;
    logic             ecnt_sat;
    logic             in_range;
    logic             measuring;

    freq_mon_sync u_sync (
        .clk         (clk),
        .reset_n     (reset_n),
        .async_in    (mon_toggle),
        .toggle_edge (toggle_edge)
    );

    assign ecnt_sat  = &ecnt;
    assign in_range  = (meas_count >= EXP_MIN_C) && (meas_count <= EXP_MAX_C);
    assign measuring = enable && (state != IDLE);

    // Window and transition counters; a window cut short by enable=0 is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wcnt       <= '0;
            ecnt       <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else if (!measuring) begin
            wcnt       <= '0;
            ecnt       <= '0;
            meas_valid <= 1'b0;
        end else if (wcnt == WCNT_LAST) begin
            wcnt       <= '0;
            ecnt       <= '0;
            meas_valid <= 1'b1;
            if (toggle_edge && !ecnt_sat) begin
                meas_count <= ecnt + 1'b1;
            end else begin
                meas_count <= ecnt;
            end
        end else begin
            wcnt       <= wcnt + 1'b1;
            meas_valid <= 1'b0;
            if (toggle_edge && !ecnt_sat) begin
                ecnt <= ecnt + 1'b1;
            end
        end
    end

    // clk_ok is a flop rather than a state decode so the reset line never glitches.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            gcnt   <= '0;
            fault  <= 1'b0;
            clk_ok <= 1'b0;
        end else begin
            state  <= state_nxt;
            gcnt   <= gcnt_nxt;
            fault  <= fault_nxt;
            clk_ok <= (state_nxt == LOCKED);
        end
    end

    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        fault_nxt = fault;
        if (!enable) begin
            state_nxt = IDLE;
            gcnt_nxt  = '0;
            fault_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = ACQUIRE;
                    gcnt_nxt  = '0;
                end
                ACQUIRE, FAULT: begin
                    if (meas_valid) begin
                        if (!in_range) begin
                            gcnt_nxt = '0;
                        end else if (gcnt == GOOD_LAST) begin
                            state_nxt = LOCKED;
                            gcnt_nxt  = '0;
                        end else begin
                            gcnt_nxt = gcnt + 1'b1;
                        end
                    end
                end
                LOCKED: begin
                    if (meas_valid && !in_range) begin
                        state_nxt = FAULT;
                        gcnt_nxt  = '0;
                        fault_nxt = 1'b1;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    gcnt_nxt  = '0;
                end
            endcase
        end
    end

    assign sys_reset_n = clk_ok;

endmodule
